// File: rtl/exu_wb_arbiter_pkg.sv
// Shared writeback types: arbitration mode, the default-width beat layout, and a modulo-increment helper.
// Pure types and functions; no state, latency or flow control.
package exu_wb_arbiter_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int INSTR_LEN_DEF = 32;
    localparam int RF_AW_DEF     = 5;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]      data;
        logic [RF_AW_DEF-1:0]     rd_addr;
        logic [XLEN_DEF-1:0]      tag;
        logic [INSTR_LEN_DEF-1:0] instr;
    } wb_beat_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/exu_wb_fifo.sv
// Single-clock FIFO of writeback beats; a pushed beat is visible at head_o after the pushing edge.
// full_o comes from registered pointers only, so a pop in the same cycle never opens space early.
module exu_wb_fifo
    import exu_wb_arbiter_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter type beat_t = wb_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  beat_t push_beat_i,
    input  logic  pop_i,
    output logic  full_o,
    output logic  empty_o,
    output beat_t head_o
);

    localparam int AW = $clog2(DEPTH);

    // The extra MSB on each pointer separates the full and empty cases when the indices match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    beat_t       mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_beat_i;
        end
    end

endmodule

// File: rtl/exu_wb_arbiter.sv
// Merges NUM_CH buffered producer channels into one registered register-file write; 2-cycle uncontended latency.
// Each channel backpressures through ch_ready = !ch_full; rd_addr==0 beats are accepted and dropped.
module exu_wb_arbiter
    import exu_wb_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 2,
    parameter int ARB_MODE  = 1,
    parameter int XLEN      = 32,
    parameter int INSTR_LEN = 32,
    parameter int RF_AW     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_ready,
    input  logic [NUM_CH*XLEN-1:0]      ch_data,
    input  logic [NUM_CH*RF_AW-1:0]     ch_rd_addr,
    input  logic [NUM_CH*XLEN-1:0]      ch_tag,
    input  logic [NUM_CH*INSTR_LEN-1:0] ch_instr,
    output logic [XLEN-1:0]             wb_data,
    output logic [RF_AW-1:0]            wb_rd_addr,
    output logic                        wb_rd_wr_en,
    output logic [XLEN-1:0]             wb_tag,
    output logic [INSTR_LEN-1:0]        wb_instr,
    output logic [NUM_CH-1:0]           wb_grant,
    output logic [NUM_CH-1:0]           ch_full,
    output logic [15:0]                 conflict_cnt
);

    localparam int PW = $clog2(NUM_CH);

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [RF_AW-1:0]     rd_addr;
        logic [XLEN-1:0]      tag;
        logic [INSTR_LEN-1:0] instr;
    } beat_t;

    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_push;
    logic [NUM_CH-1:0] head_vld;
    beat_t             in_beat [NUM_CH];
    beat_t             head    [NUM_CH];

    logic              grant_vld;
    logic [PW-1:0]     grant_idx;
    logic [NUM_CH-1:0] grant_oh;

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]       conflict_q, conflict_d;
    logic              wb_en_q, wb_en_d;
    logic [NUM_CH-1:0] wb_grant_q, wb_grant_d;
    beat_t             wb_beat_q, wb_beat_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign in_beat[g] = '{
            data:    ch_data[g*XLEN +: XLEN],
            rd_addr: ch_rd_addr[g*RF_AW +: RF_AW],
            tag:     ch_tag[g*XLEN +: XLEN],
            instr:   ch_instr[g*INSTR_LEN +: INSTR_LEN]
        };
        assign ch_ready[g]  = !fifo_full[g];
        // x0 writes complete the handshake but are never stored.
        assign fifo_push[g] = ch_valid[g] && ch_ready[g] && (in_beat[g].rd_addr != '0);

        exu_wb_fifo #(
            .DEPTH  (DEPTH),
            .beat_t (beat_t)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (fifo_push[g]),
            .push_beat_i (in_beat[g]),
            .pop_i       (grant_oh[g]),
            .full_o      (fifo_full[g]),
            .empty_o     (fifo_empty[g]),
            .head_o      (head[g])
        );
    end

    assign head_vld = ~fifo_empty;
    assign ch_full  = fifo_full;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (ARB_MODE == int'(ARB_FIXED)) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (head_vld[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = PW'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!grant_vld && head_vld[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                    grant_vld = 1'b1;
                    grant_idx = PW'((int'(rr_ptr_q) + k) % NUM_CH);
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == PW'(i));
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        conflict_d = conflict_q;
        wb_en_d    = grant_vld;
        wb_grant_d = grant_oh;
        wb_beat_d  = wb_beat_q;
        if (grant_vld) begin
            rr_ptr_d  = PW'(wrap_inc(int'(grant_idx), NUM_CH));
            wb_beat_d = head[grant_idx];
        end
        // Saturate rather than wrap so a long-running count never reads as small.
        if ($countones(head_vld) > 1 && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            conflict_q <= '0;
            wb_en_q    <= 1'b0;
            wb_grant_q <= '0;
            wb_beat_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
            wb_en_q    <= wb_en_d;
            wb_grant_q <= wb_grant_d;
            wb_beat_q  <= wb_beat_d;
        end
    end

    assign wb_rd_wr_en  = wb_en_q;
    assign wb_grant     = wb_grant_q;
    assign wb_data      = wb_beat_q.data;
    assign wb_rd_addr   = wb_beat_q.rd_addr;
    assign wb_tag       = wb_beat_q.tag;
    assign wb_instr     = wb_beat_q.instr;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share one stimulus stream.
// Outputs are sampled 1 time unit after each rising edge.
module tb_exu_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_valid;
    logic [127:0] ch_data;
    logic [19:0]  ch_rd_addr;
    logic [127:0] ch_tag;
    logic [127:0] ch_instr;

    logic [3:0]  ready_r, grant_r, full_r;
    logic [31:0] data_r, tag_r, instr_r;
    logic [4:0]  rd_r;
    logic        en_r;
    logic [15:0] cnt_r;

    logic [3:0]  ready_f, grant_f, full_f;
    logic [31:0] data_f, tag_f, instr_f;
    logic [4:0]  rd_f;
    logic        en_f;
    logic [15:0] cnt_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exu_wb_arbiter #(.NUM_CH(4), .DEPTH(2), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ready_r),
        .ch_data(ch_data), .ch_rd_addr(ch_rd_addr), .ch_tag(ch_tag), .ch_instr(ch_instr),
        .wb_data(data_r), .wb_rd_addr(rd_r), .wb_rd_wr_en(en_r), .wb_tag(tag_r),
        .wb_instr(instr_r), .wb_grant(grant_r), .ch_full(full_r), .conflict_cnt(cnt_r)
    );

    exu_wb_arbiter #(.NUM_CH(4), .DEPTH(2), .ARB_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ready_f),
        .ch_data(ch_data), .ch_rd_addr(ch_rd_addr), .ch_tag(ch_tag), .ch_instr(ch_instr),
        .wb_data(data_f), .wb_rd_addr(rd_f), .wb_rd_wr_en(en_f), .wb_tag(tag_f),
        .wb_instr(instr_f), .wb_grant(grant_f), .ch_full(full_f), .conflict_cnt(cnt_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [31:0] d, input logic [4:0] rd);
        ch_valid[i]            = v;
        ch_data[i*32 +: 32]    = d;
        ch_rd_addr[i*5 +: 5]   = rd;
        ch_tag[i*32 +: 32]     = d ^ 32'h5A5A_0000;
        ch_instr[i*32 +: 32]   = 32'h0000_0013 | {20'h0, 7'h0, rd};
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        chk("rst_ready_r", 32'(ready_r), 32'hF);
        chk("rst_ready_f", 32'(ready_f), 32'hF);
        chk("rst_en_r", 32'(en_r), 32'h0);
        chk("rst_grant_r", 32'(grant_r), 32'h0);
        chk("rst_data_r", data_r, 32'h0);
        chk("rst_cnt_r", 32'(cnt_r), 32'h0);
        rst = 1'b0;

        // Single uncontended beat on ch2.
        drive(2, 1'b1, 32'hDEAD_BEEF, 5'd7);
        tick();
        idle_all();
        chk("t1_en_e0", 32'(en_r), 32'h0);
        tick();
        chk("t1_en_e1", 32'(en_r), 32'h1);
        chk("t1_rd", 32'(rd_r), 32'd7);
        chk("t1_data", data_r, 32'hDEAD_BEEF);
        chk("t1_tag", tag_r, 32'hDEAD_BEEF ^ 32'h5A5A_0000);
        chk("t1_grant_r", 32'(grant_r), 32'h4);
        chk("t1_grant_f", 32'(grant_f), 32'h4);
        chk("t1_cnt", 32'(cnt_r), 32'h0);
        tick();
        chk("t1_en_off", 32'(en_r), 32'h0);
        chk("t1_grant_off", 32'(grant_r), 32'h0);
        chk("t1_data_hold", data_r, 32'hDEAD_BEEF);

        // Four simultaneous beats drain in index order.
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 32'h100 + 32'(i), 5'(i + 1));
        tick();
        idle_all();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("t2_en_%0d", n), 32'(en_r), 32'h1);
            chk($sformatf("t2_grant_r_%0d", n), 32'(grant_r), 32'(1) << n);
            chk($sformatf("t2_rd_%0d", n), 32'(rd_r), 32'(n + 1));
            chk($sformatf("t2_data_%0d", n), data_r, 32'h100 + 32'(n));
            chk($sformatf("t2_grant_f_%0d", n), 32'(grant_f), 32'(1) << n);
        end
        chk("t2_cnt_r", 32'(cnt_r), 32'd3);
        chk("t2_cnt_f", 32'(cnt_f), 32'd3);
        tick();
        chk("t2_en_idle", 32'(en_r), 32'h0);

        // ch0 and ch3 stream: fixed priority starves ch3, round-robin alternates.
        do_reset();
        drive(0, 1'b1, 32'h1000, 5'd10);
        drive(3, 1'b1, 32'h3A, 5'd20);
        tick();
        chk("t3_ready3_e0", 32'(ready_f[3]), 32'h1);
        drive(0, 1'b1, 32'h1001, 5'd10);
        drive(3, 1'b1, 32'h3B, 5'd21);
        tick();
        chk("t3_grant_e1", 32'(grant_f), 32'h1);
        chk("t3_data_e1", data_f, 32'h1000);
        chk("t3_full3", 32'(full_f[3]), 32'h1);
        chk("t3_ready3", 32'(ready_f[3]), 32'h0);
        chk("t3_rr_grant_e1", 32'(grant_r), 32'h1);
        drive(0, 1'b1, 32'h1002, 5'd10);
        drive(3, 1'b1, 32'h3C, 5'd22);
        tick();
        chk("t3_grant_e2", 32'(grant_f), 32'h1);
        chk("t3_data_e2", data_f, 32'h1001);
        chk("t3_ready3_e2", 32'(ready_f[3]), 32'h0);
        chk("t3_rr_grant_e2", 32'(grant_r), 32'h8);
        chk("t3_rr_data_e2", data_r, 32'h3A);
        drive(0, 1'b1, 32'h1003, 5'd10);
        tick();
        chk("t3_data_e3", data_f, 32'h1002);
        drive(0, 1'b0, 32'h0, 5'd0);
        tick();
        chk("t3_grant_e4", 32'(grant_f), 32'h1);
        chk("t3_data_e4", data_f, 32'h1003);
        tick();
        chk("t3_grant_e5", 32'(grant_f), 32'h8);
        chk("t3_data_e5", data_f, 32'h3A);
        chk("t3_rd_e5", 32'(rd_f), 32'd20);
        chk("t3_ready3_e5", 32'(ready_f[3]), 32'h1);
        tick();
        chk("t3_data_e6", data_f, 32'h3B);
        drive(3, 1'b0, 32'h0, 5'd0);
        tick();
        chk("t3_data_e7", data_f, 32'h3C);
        chk("t3_rd_e7", 32'(rd_f), 32'd22);
        tick();
        chk("t3_en_e8", 32'(en_f), 32'h0);

        // x0 destination is swallowed.
        do_reset();
        drive(1, 1'b1, 32'h55, 5'd0);
        tick();
        idle_all();
        chk("t4_ready1", 32'(ready_r[1]), 32'h1);
        chk("t4_full1", 32'(full_r[1]), 32'h0);
        tick();
        chk("t4_en_r_a", 32'(en_r), 32'h0);
        chk("t4_en_f_a", 32'(en_f), 32'h0);
        tick();
        chk("t4_en_r_b", 32'(en_r), 32'h0);

        // Full ch1: the popping cycle stays not-ready; order A, B, C preserved.
        do_reset();
        drive(0, 1'b1, 32'hC0, 5'd3);
        drive(1, 1'b1, 32'hA1, 5'd11);
        tick();
        drive(0, 1'b1, 32'hC1, 5'd3);
        drive(1, 1'b1, 32'hB1, 5'd12);
        tick();
        chk("t5_full1", 32'(full_f[1]), 32'h1);
        chk("t5_ready1", 32'(ready_f[1]), 32'h0);
        drive(0, 1'b0, 32'h0, 5'd0);
        drive(1, 1'b1, 32'hCC1, 5'd13);
        tick();
        chk("t5_data_c1", data_f, 32'hC1);
        chk("t5_ready1_pop", 32'(ready_f[1]), 32'h0);
        tick();
        chk("t5_grant_a", 32'(grant_f), 32'h2);
        chk("t5_data_a", data_f, 32'hA1);
        chk("t5_ready1_after", 32'(ready_f[1]), 32'h1);
        tick();
        chk("t5_data_b", data_f, 32'hB1);
        chk("t5_full1_pp", 32'(full_f[1]), 32'h0);
        chk("t5_ready1_pp", 32'(ready_f[1]), 32'h1);
        drive(1, 1'b0, 32'h0, 5'd0);
        tick();
        chk("t5_data_c", data_f, 32'hCC1);
        chk("t5_rd_c", 32'(rd_f), 32'd13);
        tick();
        chk("t5_en_idle", 32'(en_f), 32'h0);

        // Reset mid-drain discards the queued beats.
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 32'h600 + 32'(i), 5'(i + 1));
        tick();
        idle_all();
        tick();
        chk("t6_en_before", 32'(en_f), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_en_r_rst", 32'(en_r), 32'h0);
        chk("t6_en_f_rst", 32'(en_f), 32'h0);
        chk("t6_ready_r_rst", 32'(ready_r), 32'hF);
        chk("t6_ready_f_rst", 32'(ready_f), 32'hF);
        chk("t6_grant_rst", 32'(grant_r), 32'h0);
        chk("t6_data_rst", data_r, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk($sformatf("t6_en_r_post%0d", n), 32'(en_r), 32'h0);
            chk($sformatf("t6_en_f_post%0d", n), 32'(en_f), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_wb_arbiter.md
Name: exu_wb_arbiter

Overview:
- Parametrised writeback arbiter for the execution unit, generalising the single-winner OR-merge of ALU/MUL/DIV/LSU results into NUM_CH buffered producer channels.
- Each channel gets a small FIFO with a valid/ready handshake, so simultaneous completions are queued instead of corrupting the merged bus.
- One registered writeback per cycle goes to the IDU1 register-file write port, selected by fixed-priority or round-robin arbitration.
- Per-channel backpressure replaces the ad-hoc busy/stall signalling of the functional units.

Parameters:
- NUM_CH, 4, number of producer channels (2..8).
- DEPTH, 2, per-channel FIFO entries (power of two, >=2).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- XLEN, 32, data and tag width.
- INSTR_LEN, 32, debug instruction width.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_valid  in  NUM_CH  producer beat valid, one bit per channel.
- ch_ready  out  NUM_CH  channel can accept a beat.
- ch_data  in  NUM_CH*XLEN  result data, channel i at [i*XLEN +: XLEN].
- ch_rd_addr  in  NUM_CH*RF_AW  destination register.
- ch_tag  in  NUM_CH*XLEN  debug instruction tag.
- ch_instr  in  NUM_CH*INSTR_LEN  debug instruction word.
- wb_data  out  XLEN  writeback data.
- wb_rd_addr  out  RF_AW  writeback register.
- wb_rd_wr_en  out  1  writeback strobe.
- wb_tag  out  XLEN  debug tag of the written beat.
- wb_instr  out  INSTR_LEN  debug instruction of the written beat.
- wb_grant  out  NUM_CH  one-hot source of the current writeback.
- ch_full  out  NUM_CH  FIFO occupancy == DEPTH.
- conflict_cnt  out  16  count of cycles where more than one FIFO head was valid.

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty; ch_ready all 1.
  - wb_rd_wr_en = 0; wb_data, wb_rd_addr, wb_tag, wb_instr, wb_grant = 0.
  - Round-robin pointer = 0; conflict_cnt = 0.
- Enqueue: beat accepted on a rising edge when ch_valid[i] && ch_ready[i].
- ch_ready[i] = !ch_full[i], registered-occupancy based only.
  - A pop in the same cycle does not raise ready: a full FIFO stays not-ready for that cycle.
- rd_addr == 0 beats:
  - Accepted (handshake completes) but not stored.
  - Never produce a writeback.
- Simultaneous push and pop on one FIFO: occupancy unchanged; FIFO order is preserved.
- Pointer wrap-around at DEPTH is modulo, with a separate full/empty distinction (extra pointer bit).
- Arbitration runs each cycle over non-empty FIFO heads:
  - ARB_MODE 0: grant lowest index.
  - ARB_MODE 1: grant first non-empty index at or after rr_ptr, wrapping modulo NUM_CH.
  - After a grant, rr_ptr = granted index + 1, mod NUM_CH.
  - No grant means no pointer change.
- The granted head is popped on the same edge that loads the output registers.
- Output registers:
  - wb_rd_wr_en = 1 for exactly one cycle per granted beat; the other wb_* fields hold the granted entry.
  - With no grant: wb_rd_wr_en = 0, wb_grant = 0, and data fields hold their last value.
- Latency:
  - Beat accepted at edge k is at the FIFO head after k.
  - If uncontended it is granted at edge k+1, so wb_rd_wr_en is high in the cycle after edge k+1 (2 cycles).
- Throughput: one writeback per cycle aggregate; each channel sustains 1 beat/cycle when alone and DEPTH >= 2.
- conflict_cnt increments when at least two heads are valid in a cycle; saturates at 0xFFFF, no wrap.
- Reset mid-operation discards all queued beats; no partial writeback is emitted after rst deasserts.

Decomposition:
- Shared types package (types.svh) gains:
  - arb_mode_e enum (ARB_FIXED = 0, ARB_RR = 1).
  - wb_beat_t struct: data, rd_addr, tag, instr.
- One sub-module, exu_wb_fifo: single-clock synchronous FIFO of wb_beat_t with parameter DEPTH; ports push/pop/full/empty/head.
  - Instantiated NUM_CH times via generate.
- The arbiter and output registers live in the top.

Test Plan:
- Single beat, ch2, rd 7, data 0xDEADBEEF, accepted at edge 0 -> wb_rd_wr_en high after edge 1 with rd_addr 7, data 0xDEADBEEF, wb_grant 0b0100; conflict_cnt stays 0.
- ARB_MODE 1, all 4 channels push one beat (rd 1..4) in the same cycle -> writebacks in order ch0, ch1, ch2, ch3 on 4 consecutive cycles; conflict_cnt = 3.
- ARB_MODE 0, ch0 and ch3 stream continuously -> ch0 granted every cycle; ch3 fills to DEPTH = 2, ch_full[3] = 1, ch_ready[3] = 0, ch3 beats not lost.
- Push with rd 0, data 0x55 on ch1 -> ch_ready[1] stays 1, no wb_rd_wr_en pulse.
- Fill ch1 with 2 beats, then pop and push in the same cycle -> ready stays 0 that cycle, occupancy stays 2, output order is beat A, B, C.
- Assert rst with 3 queued beats -> wb_rd_wr_en 0 immediately, ch_ready all 1, no writebacks after release.
